// File: rtl/libhdl_sync_bus_filter_if.sv
// Bus handshake between a synchronizer output (master side) and the bus filter (slave side).
// The master drives the raw synchronized bus; the filter returns the committed bus and its status flags.
interface libhdl_sync_bus_filter_if #(
    parameter int W = 32
);
    logic [W-1:0] i_bus;
    logic [W-1:0] o_bus;
    logic         o_valid;
    logic         o_update;
    logic         o_settling;

    modport master (output i_bus, input o_bus, o_valid, o_update, o_settling);
    modport slave  (input i_bus, output o_bus, o_valid, o_update, o_settling);
endinterface

// File: rtl/libhdl_sync_bus_filter.sv
// Skew filter for a multi-flop bus synchronizer: a value is forwarded only after it
// has been sampled identically on STABLE_CYCLES consecutive edges.
module libhdl_sync_bus_filter #(
    parameter int             W             = 32,
    parameter int             STABLE_CYCLES = 4,
    parameter logic [W-1:0]   INIT_VAL      = '0
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    libhdl_sync_bus_filter_if.slave b
);
    localparam int            CW  = $clog2(STABLE_CYCLES + 1);
    localparam logic [CW-1:0] SAT = CW'(STABLE_CYCLES);

    logic [W-1:0]  cand;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic          commit;
    logic [W-1:0]  bus_q;
    logic          valid_q;
    logic          update_q;
    logic          settling_q;

    // Run length of identical samples, saturating so long idle periods never wrap.
    always_comb begin
        cnt_n = CW'(1);
        if (b.i_bus == cand)
            cnt_n = (cnt == SAT) ? SAT : cnt + CW'(1);
    end

    // A settled run equal to the committed value is not re-committed (no spurious strobe).
    assign commit = (cnt_n == SAT) && (!valid_q || (b.i_bus != bus_q));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cand       <= INIT_VAL;
            cnt        <= '0;
            bus_q      <= INIT_VAL;
            valid_q    <= 1'b0;
            update_q   <= 1'b0;
            settling_q <= 1'b1;
        end else begin
            cand       <= b.i_bus;
            cnt        <= cnt_n;
            update_q   <= commit;
            settling_q <= (cnt_n != SAT);
            if (commit) begin
                bus_q   <= b.i_bus;
                valid_q <= 1'b1;
            end
        end
    end

    assign b.o_bus      = bus_q;
    assign b.o_valid    = valid_q;
    assign b.o_update   = update_q;
    assign b.o_settling = settling_q;
endmodule

// File: tb/tb_libhdl_sync_bus_filter.sv
// Randomized and directed bench for the bus filter, N=4 and N=1 builds side by side,
// checked against a model that works from the sample history since reset.
module tb_libhdl_sync_bus_filter;
    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [7:0] din;
    int         checks = 0;
    int         errors = 0;

    always #5 i_clk = ~i_clk;

    libhdl_sync_bus_filter_if #(.W(8)) b4 ();
    libhdl_sync_bus_filter_if #(.W(8)) b1 ();
    assign b4.i_bus = din;
    assign b1.i_bus = din;

    libhdl_sync_bus_filter #(.W(8), .STABLE_CYCLES(4), .INIT_VAL(8'h00)) u4 (
        .i_clk(i_clk), .i_rst(i_rst), .b(b4.slave));
    libhdl_sync_bus_filter #(.W(8), .STABLE_CYCLES(1), .INIT_VAL(8'h00)) u1 (
        .i_clk(i_clk), .i_rst(i_rst), .b(b1.slave));

    typedef struct {
        logic [7:0] obus;
        logic       valid;
        logic       upd;
        logic       settl;
    } mdl_t;

    localparam mdl_t MDL_RST = '{obus: 8'h00, valid: 1'b0, upd: 1'b0, settl: 1'b1};

    mdl_t       m4, m1;
    logic [7:0] hist[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s obs=%0h exp=%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    // Number of trailing identical samples since reset.
    function automatic int run_len();
        int r;
        int n;
        n = hist.size();
        if (n == 0) return 0;
        r = 1;
        for (int i = n - 2; i >= 0; i--) begin
            if (hist[i] != hist[n-1]) break;
            r++;
        end
        return r;
    endfunction

    function automatic mdl_t mdl_next(input mdl_t m, input int n, input logic [7:0] x, input int run);
        mdl_t r;
        r     = m;
        r.upd = 1'b0;
        if (run >= n && (!m.valid || x != m.obus)) begin
            r.obus  = x;
            r.valid = 1'b1;
            r.upd   = 1'b1;
        end
        r.settl = (run < n);
        return r;
    endfunction

    task automatic cyc(input logic [7:0] x, input logic rst);
        int run;
        @(negedge i_clk);
        din   = x;
        i_rst = rst;
        @(posedge i_clk);
        if (rst) begin
            hist.delete();
            m4 = MDL_RST;
            m1 = MDL_RST;
        end else begin
            hist.push_back(x);
            if (hist.size() > 16) void'(hist.pop_front());
            run = run_len();
            m4  = mdl_next(m4, 4, x, run);
            m1  = mdl_next(m1, 1, x, run);
        end
        #1;
        chk("n4_bus",   32'(b4.o_bus),      32'(m4.obus));
        chk("n4_valid", 32'(b4.o_valid),    32'(m4.valid));
        chk("n4_upd",   32'(b4.o_update),   32'(m4.upd));
        chk("n4_settl", 32'(b4.o_settling), 32'(m4.settl));
        chk("n1_bus",   32'(b1.o_bus),      32'(m1.obus));
        chk("n1_valid", 32'(b1.o_valid),    32'(m1.valid));
        chk("n1_upd",   32'(b1.o_update),   32'(m1.upd));
        chk("n1_settl", 32'(b1.o_settling), 32'(m1.settl));
    endtask

    initial begin
        logic [7:0] pool [5];
        logic [7:0] v;
        int         seen;
        int         lat;
        int         hold;
        pool = '{8'h00, 8'hA5, 8'h5A, 8'hFF, 8'h3C};
        din   = 8'h00;
        i_rst = 1'b1;
        m4    = MDL_RST;
        m1    = MDL_RST;

        // 1: reset, then hold 0x00; INIT_VAL commits on the 4th edge.
        cyc(8'h00, 1'b1);
        chk("rst_valid", 32'(b4.o_valid), 32'd0);
        chk("rst_settl", 32'(b4.o_settling), 32'd1);
        for (int i = 0; i < 3; i++) cyc(8'h00, 1'b0);
        chk("t1_valid_lo", 32'(b4.o_valid), 32'd0);
        cyc(8'h00, 1'b0);
        chk("t1_upd", 32'(b4.o_update), 32'd1);
        cyc(8'h00, 1'b0);
        chk("t1_upd_single", 32'(b4.o_update), 32'd0);

        // 2: move to 0xA5 and hold.
        for (int i = 0; i < 3; i++) cyc(8'hA5, 1'b0);
        chk("t2_bus_hold", 32'(b4.o_bus), 32'h00);
        cyc(8'hA5, 1'b0);
        chk("t2_bus_new", 32'(b4.o_bus), 32'hA5);
        for (int i = 0; i < 20; i++) cyc(8'hA5, 1'b0);  // long hold: counter must saturate
        chk("t2_settl_lo", 32'(b4.o_settling), 32'd0);

        // 3: skew glitch returning to the committed value.
        seen = 0;
        cyc(8'h5A, 1'b0); seen += int'(b4.o_update);
        cyc(8'hA4, 1'b0); seen += int'(b4.o_update);
        for (int i = 0; i < 6; i++) begin
            cyc(8'hA5, 1'b0);
            seen += int'(b4.o_update);
        end
        chk("t3_no_upd", 32'(seen), 32'd0);
        chk("t3_bus", 32'(b4.o_bus), 32'hA5);

        // 4: alternating values that never settle.
        seen = 0;
        for (int i = 0; i < 50; i++) begin
            cyc(((i / 3) % 2 == 0) ? 8'h11 : 8'h22, 1'b0);
            seen += int'(b4.o_update);
        end
        chk("t4_no_upd", 32'(seen), 32'd0);
        chk("t4_bus", 32'(b4.o_bus), 32'hA5);

        // 5: reset mid-settle, then latency from reset release.
        cyc(8'h3C, 1'b0);
        cyc(8'h3C, 1'b0);
        cyc(8'h3C, 1'b1);
        chk("t5_bus_rst", 32'(b4.o_bus), 32'h00);
        lat = 0;
        for (int i = 1; i <= 8 && lat == 0; i++) begin
            cyc(8'h3C, 1'b0);
            if (b4.o_update) lat = i;
        end
        chk("t5_latency", 32'(lat), 32'd4);

        // 6: N=1 build behaves as register plus change strobe.
        cyc(8'h01, 1'b0); chk("t6_upd_a", 32'(b1.o_update), 32'd1);
        cyc(8'h02, 1'b0); chk("t6_upd_b", 32'(b1.o_update), 32'd1);
        cyc(8'h02, 1'b0); chk("t6_upd_rep", 32'(b1.o_update), 32'd0);
        cyc(8'h03, 1'b0); chk("t6_bus", 32'(b1.o_bus), 32'h03);

        // Random holds over a small value pool, with occasional resets.
        for (int n = 0; n < 150; n++) begin
            v    = ($urandom_range(0, 4) == 0) ? 8'($urandom) : pool[$urandom_range(0, 4)];
            hold = $urandom_range(1, 6);
            for (int i = 0; i < hold; i++) cyc(v, ($urandom_range(0, 60) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/libhdl_sync_bus_filter.md
Name: libhdl_sync_bus_filter

Overview:
- Downstream consumer of a multi-flop bus synchronizer output. Removes the multi-bit skew hazard: a new value is forwarded only after it has been sampled identically on STABLE_CYCLES consecutive clock edges.
- Single clock domain, the destination domain of the synchronizer. Provides a registered filtered bus, a valid flag, and a one-cycle update strobe for downstream register banks and config latches.

Parameters:
- W, 32, bus width in bits (>=1).
- STABLE_CYCLES, 4, consecutive identical samples required before commit (>=1; 1 = plain register, 1-cycle latency).
- INIT_VAL, {W{1'b0}}, reset value of o_bus and of the internal candidate register.

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_bus  in  W  bus from synchronizer, already in the i_clk domain; may be skewed or glitching for several cycles after a source change.
- o_bus  out  W  filtered bus; changes only on a commit.
- o_valid  out  1  0 from reset until the first commit; 1 afterwards until the next reset.
- o_update  out  1  1-cycle pulse, coincident with the cycle in which o_bus shows a newly committed value.
- o_settling  out  1  1 while the candidate has not yet reached STABLE_CYCLES matches; registered, derived from the counter.

Behaviour:
- Internal state:
  - cand[W]: last sample.
  - cnt: width clog2(STABLE_CYCLES+1), saturating at STABLE_CYCLES.
- Reset (i_rst=1 at an edge):
  - cand=INIT_VAL, cnt=0, o_bus=INIT_VAL, o_valid=0, o_update=0, o_settling=1.
  - Reset has priority over every other event.
  - Reset mid-settle discards the candidate and count; a committed o_bus reverts to INIT_VAL.
- Each non-reset edge:
  - cnt_n = (i_bus==cand) ? min(cnt+1, STABLE_CYCLES) : 1; cand <= i_bus; cnt <= cnt_n.
  - commit = (cnt_n==STABLE_CYCLES) && (!o_valid || i_bus!=o_bus).
  - On commit: o_bus <= i_bus, o_valid <= 1, o_update <= 1. Otherwise o_update <= 0 and o_bus holds.
  - o_settling <= (cnt_n != STABLE_CYCLES).
- States, derived and not separately encoded:
  - INIT: o_valid=0.
  - SETTLE: o_valid=1, cnt<STABLE_CYCLES.
  - STABLE: cnt==STABLE_CYCLES and cand==o_bus.
  - INIT→STABLE on the first commit. STABLE→SETTLE on any sample differing from cand. SETTLE→STABLE on commit, or on cnt reaching STABLE_CYCLES with a value equal to o_bus (no update pulse). Any state→INIT on reset.
- Latency: a value first sampled at edge k and held is visible on o_bus, with o_update=1, after edge k+STABLE_CYCLES-1.
- Glitch return: if i_bus deviates then returns to the committed value, nothing is committed. o_update stays 0 and o_bus does not move.
- Continuous change: a value that never holds for STABLE_CYCLES samples is never committed. o_bus holds its last value indefinitely and o_settling stays 1.
- Back-to-back updates: a new value differing at the edge right after a commit restarts cnt at 1. Minimum spacing between o_update pulses is STABLE_CYCLES cycles.
- After reset with i_bus==INIT_VAL: INIT_VAL is committed after STABLE_CYCLES edges, with o_valid rising and o_update pulsing.
- Counter saturates; no wrap-around for arbitrarily long stable input.
- STABLE_CYCLES=1: commit on every sample differing from o_bus; acts as a register plus change strobe.

Test Plan:
1. W=8, N=4. Reset, then hold i_bus=0x00. Required: o_valid=0 for 3 cycles; after the 4th edge o_bus=0x00, o_valid=1, single o_update pulse.
2. From stable 0x00, set i_bus=0xA5 and hold. Required: o_bus=0x00 for 3 edges, o_settling=1; after the 4th edge o_bus=0xA5 with one o_update; o_settling=0 thereafter.
3. From stable 0xA5, drive 0x5A, 0xA4, 0xA5 for one cycle each (skew glitch), then hold 0xA5. Required: o_bus stays 0xA5, no o_update, o_settling falls 4 cycles after the return to 0xA5.
4. Toggle i_bus between 0x11 and 0x22 every 3 cycles for 50 cycles with N=4. Required: no commit, o_update never asserted, o_bus unchanged.
5. Present 0x3C for 2 cycles then assert i_rst for 1 cycle, then hold 0x3C. Required: after reset o_bus=0x00, o_valid=0; commit of 0x3C occurs exactly 4 edges after reset release.
6. N=1 build: drive 0x01, 0x02, 0x02, 0x03. Required: o_bus follows with 1-cycle latency; o_update=1 on each change, 0 on the repeated 0x02.
